sti_deser: RTL and testbench

- Downstream receive stage for the STI_DAC serial output.
- Samples the so_data/so_valid bit stream and rebuilds frames of 8/16/24/32 bits using the same length and bit-order controls as the transmitter.
- Writes each rebuilt frame into the pixel memory one byte at a time, most significant byte first, at consecutive addresses.
- Flags short frames and overruns, and raises pixel_finish once the stream has ended and every byte has been written.

---
 rtl/sti_deser.sv | 172 +++++++++++++++++
 tb/tb_sti_deser.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sti_deser.sv
// STI_DAC serial receive stage: rebuilds 8/16/24/32-bit frames and writes them byte-wise, MSB byte first.
// Optional: define DESER_FRAME_CNT_EN to add the frame_cnt[15:0] written-frame counter output.
module sti_deser #(
   parameter int unsigned MAX_ADDR = 255,
   parameter int unsigned ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              so_data,
   input  logic              so_valid,
   input  logic [1:0]        pi_length,
   input  logic              pi_msb,
   input  logic              pi_end,
   output logic              pixel_wr,
   output logic [ADDR_W-1:0] pixel_addr,
   output logic [7:0]        pixel_dataout,
   output logic              pixel_finish,
   output logic              frame_err,
   output logic              overrun
`ifdef DESER_FRAME_CNT_EN
   ,
   output logic [15:0]       frame_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, WR_HI, WR_LO, DONE} state_t;

   state_t      state, state_nxt;
   logic [1:0]  len_q;
   logic        msb_q;
   logic [31:0] shift_q;
   logic [5:0]  bit_cnt;
   logic [31:0] hold_word;
   logic [2:0]  bytes_left;

   logic        active, first_bit, msb_cur, frame_done, short_drop, seq_free;
   logic        load, advance, byte_end;
   logic [1:0]  len_cur;
   logic [5:0]  n_bits, bit_cnt_inc;
   logic [4:0]  align_sh;
   logic [31:0] shift_base, shift_nxt, aligned;

   // The first bit of a frame uses the live controls; later bits use the latched copy.
   always_comb begin
      active      = so_valid && (state != DONE);
      first_bit   = (bit_cnt == 6'd0);
      len_cur     = first_bit ? pi_length : len_q;
      msb_cur     = first_bit ? pi_msb : msb_q;
      n_bits      = {1'b0, len_cur, 3'b000} + 6'd8;
      bit_cnt_inc = bit_cnt + 6'd1;
      shift_base  = first_bit ? 32'h0 : shift_q;
      shift_nxt   = msb_cur ? {shift_base[30:0], so_data}
                            : (shift_base | (32'(so_data) << bit_cnt));
      align_sh    = {~len_cur, 3'b000};
      aligned     = shift_nxt << align_sh;
      frame_done  = active && (bit_cnt_inc == n_bits);
      short_drop  = !so_valid && (bit_cnt != 6'd0);
      // The sequencer may take a new frame on the edge it retires its last byte.
      seq_free    = (state == IDLE) || ((state == WR_LO) && (bytes_left == 3'd1));
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      advance   = 1'b0;
      byte_end  = 1'b0;
      case (state)
         IDLE: begin
            if (frame_done) begin
               state_nxt = WR_HI;
               load      = 1'b1;
            end else if (pi_end && !so_valid && (bit_cnt == 6'd0)) begin
               state_nxt = DONE;
            end
         end
         WR_HI: state_nxt = WR_LO;
         WR_LO: begin
            if (bytes_left == 3'd1) begin
               byte_end = 1'b1;
               if (frame_done) begin
                  state_nxt = WR_HI;
                  load      = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               state_nxt = WR_HI;
               advance   = 1'b1;
            end
         end
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Bit assembly and error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_q     <= 2'd0;
         msb_q     <= 1'b0;
         shift_q   <= 32'h0;
         bit_cnt   <= 6'd0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= short_drop;
         if (frame_done && !seq_free) begin
            overrun <= 1'b1;
         end
         if (active) begin
            shift_q <= shift_nxt;
            bit_cnt <= frame_done ? 6'd0 : bit_cnt_inc;
            if (first_bit) begin
               len_q <= pi_length;
               msb_q <= pi_msb;
            end
         end else if (short_drop) begin
            bit_cnt <= 6'd0;
         end
      end
   end

   // Write datapath: hold_word keeps the remaining bytes left-aligned.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_word     <= 32'h0;
         bytes_left    <= 3'd0;
         pixel_addr    <= '0;
         pixel_dataout <= 8'h00;
         pixel_wr      <= 1'b0;
      end else begin
         pixel_wr <= (state_nxt == WR_HI);
         if (advance || byte_end) begin
            pixel_addr <= (pixel_addr == ADDR_W'(MAX_ADDR)) ? '0 : pixel_addr + ADDR_W'(1);
         end
         if (load) begin
            hold_word     <= aligned;
            pixel_dataout <= aligned[31:24];
            bytes_left    <= {1'b0, len_cur} + 3'd1;
         end else if (advance) begin
            hold_word     <= hold_word << 8;
            pixel_dataout <= hold_word[23:16];
            bytes_left    <= bytes_left - 3'd1;
         end else if (byte_end) begin
            bytes_left    <= 3'd0;
         end
      end
   end

   assign pixel_finish = (state == DONE);

`ifdef DESER_FRAME_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_cnt <= 16'h0;
      end else if (byte_end && (frame_cnt != 16'hFFFF)) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sti_deser.sv
// Scoreboard bench for sti_deser: random and directed frames against a byte-level reference model.
// Frame counter checks are included when DESER_FRAME_CNT_EN is defined.
module tb_sti_deser;

   localparam int TB_MAX_ADDR = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       so_data, so_valid, pi_msb, pi_end;
   logic [1:0] pi_length;
   logic       pixel_wr, pixel_finish, frame_err, overrun;
   logic [7:0] pixel_addr, pixel_dataout;
`ifdef DESER_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   sti_deser #(.MAX_ADDR(TB_MAX_ADDR), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .so_data(so_data), .so_valid(so_valid),
      .pi_length(pi_length), .pi_msb(pi_msb), .pi_end(pi_end),
      .pixel_wr(pixel_wr), .pixel_addr(pixel_addr), .pixel_dataout(pixel_dataout),
      .pixel_finish(pixel_finish), .frame_err(frame_err), .overrun(overrun)
`ifdef DESER_FRAME_CNT_EN
      , .frame_cnt(frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0, errors = 0;
   int  err_exp = 0, err_seen = 0;
   int  frames_exp = 0;
   int  model_addr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a frame of N bits becomes N/8 writes, top byte first, at wrapping addresses.
   task automatic push_frame(input int len, input logic [31:0] w);
      wr_t e;
      for (int b = len; b >= 0; b--) begin
         e.addr = 8'(model_addr);
         e.data = w[8*b +: 8];
         exp_q.push_back(e);
         model_addr = (model_addr == TB_MAX_ADDR) ? 0 : model_addr + 1;
      end
      frames_exp++;
   endtask

   // Controls are valid only on the first bit; they are scrambled afterwards.
   task automatic send_frame(input int len, input bit msb, input logic [31:0] w, input bit end_on_last);
      int n = 8 * (len + 1);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         so_valid = 1'b1;
         so_data  = msb ? w[n-1-k] : w[k];
         if (k == 0) begin
            pi_length = 2'(len);
            pi_msb    = msb;
         end else begin
            pi_length = 2'($urandom);
            pi_msb    = 1'($urandom);
         end
         if (end_on_last && (k == n - 1)) pi_end = 1'b1;
      end
      push_frame(len, w);
   endtask

   task automatic send_short(input int len, input int nb);
      for (int k = 0; k < nb; k++) begin
         @(negedge clk);
         so_valid = 1'b1;
         so_data  = 1'($urandom);
         pi_length = (k == 0) ? 2'(len) : 2'($urandom);
         pi_msb    = 1'($urandom);
      end
      @(negedge clk);
      so_valid = 1'b0;
      err_exp++;
   endtask

   task automatic idle(input int c);
      repeat (c) begin
         @(negedge clk);
         so_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b0;
      so_valid = 1'b0;
      pi_end   = 1'b0;
      exp_q.delete();
      model_addr = 0;
      frames_exp = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while (exp_q.size() != 0 && t < 2000) begin
         @(negedge clk);
         so_valid = 1'b0;
         t++;
      end
      check({tag, "_drain"}, exp_q.size(), 0);
      idle(3);
      check({tag, "_frame_err"}, err_seen, err_exp);
      check({tag, "_overrun"}, overrun, 1'b0);
`ifdef DESER_FRAME_CNT_EN
      check({tag, "_frame_cnt"}, frame_cnt, frames_exp);
`endif
   endtask

   // Monitor: pops one expected write per pixel_wr pulse and checks the low phase holds it.
   wr_t cur;
   bit  prev_wr = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         prev_wr = 1'b0;
      end else begin
         if (frame_err) err_seen++;
         if (pixel_wr) begin
            check("wr_pulse_gap", prev_wr, 1'b0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got %0h@%0h expected none at %0t",
                        pixel_dataout, pixel_addr, $time);
            end else begin
               cur = exp_q.pop_front();
               check("wr_addr", pixel_addr, cur.addr);
               check("wr_data", pixel_dataout, cur.data);
            end
         end else if (prev_wr) begin
            check("hold_addr", pixel_addr, cur.addr);
            check("hold_data", pixel_dataout, cur.data);
         end
         prev_wr = pixel_wr;
      end
   end

   initial begin
      int t;
      reset = 1'b0; so_data = 1'b0; so_valid = 1'b0;
      pi_length = 2'd0; pi_msb = 1'b0; pi_end = 1'b0;
      #1;
      check("rst_wr", pixel_wr, 1'b0);
      check("rst_addr", pixel_addr, 8'h00);
      check("rst_data", pixel_dataout, 8'h00);
      check("rst_finish", pixel_finish, 1'b0);
      check("rst_err", frame_err, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // 16-bit frame, both bit orders: A5@0 then 3C@1.
      send_frame(1, 1'b1, 32'h0000A53C, 1'b0);
      drain("msb16");
      do_reset();
      send_frame(1, 1'b0, 32'h0000A53C, 1'b0);
      drain("lsb16");

      // 32-bit frame followed without a gap by an 8-bit frame.
      do_reset();
      send_frame(3, 1'b1, 32'h12345678, 1'b0);
      send_frame(0, 1'b0, 32'h000000FF, 1'b0);
      drain("b2b");

      // Short 16-bit frame (5 bits) then 8-bit 5A at address 0.
      do_reset();
      send_short(1, 5);
      send_frame(0, 1'b1, 32'h0000005A, 1'b0);
      drain("short");

      // Six 8-bit frames wrap the address; pi_end rises with the last bit.
      do_reset();
      for (int i = 1; i <= 6; i++) send_frame(0, 1'($urandom), 32'(i), i == 6);
      @(negedge clk);
      so_valid = 1'b0;
      check("finish_pending", pixel_finish, 1'b0);
      t = 0;
      while (!pixel_finish && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("finish_rise", pixel_finish, 1'b1);
      check("finish_after_writes", exp_q.size(), 0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         so_valid = 1'b1;
         so_data  = 1'($urandom);
      end
      idle(4);
      check("finish_sticky", pixel_finish, 1'b1);

      // Random traffic: mixed lengths, orders, gaps and short frames.
      do_reset();
      for (int i = 0; i < 40; i++) begin
         int len = $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) begin
            send_short(len, $urandom_range(1, 8 * (len + 1) - 1));
         end else begin
            send_frame(len, 1'($urandom), $urandom, 1'b0);
         end
         idle($urandom_range(0, 3));
      end
      drain("random");

      // Reset asserted during the low phase of a 32-bit frame's first byte.
      do_reset();
      send_frame(3, 1'b1, 32'hDEADBEEF, 1'b0);
      t = 0;
      do begin
         @(negedge clk);
         so_valid = 1'b0;
         t++;
      end while (!pixel_wr && t < 50);
      check("midwr_seen_wr", pixel_wr, 1'b1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("midrst_wr", pixel_wr, 1'b0);
      check("midrst_addr", pixel_addr, 8'h00);
      check("midrst_data", pixel_dataout, 8'h00);
      check("midrst_finish", pixel_finish, 1'b0);
      exp_q.delete();
      model_addr = 0;
      frames_exp = 0;
      @(negedge clk);
      reset = 1'b1;
      send_frame(0, 1'b0, 32'h00000077, 1'b0);
      drain("after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
